id_operand_stage: RTL

- Decode/operand-fetch pipeline stage that sits directly upstream of the execute unit and drives the register file read ports.
- Takes a fetched RV32I instruction and PC, and extracts rs1, rs2 and rd.
- Reads both operands from the register file through its combinational read ports and generates the immediate.
- Latches everything into a single ID/EX output register behind a valid/ready handshake.
- Provides write-through bypass from the writeback port, because the register file writes on posedge and reads combinationally.
- Provides a load-use interlock.

---
 rtl/rv32i_pkg.sv | 43 ++++
 rtl/id_operand_stage_if.sv | 28 ++
 rtl/imm_gen.sv | 21 ++
 rtl/id_operand_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, instruction formats and format helpers
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // FMT_X covers opcodes outside RV32I: no sources, no destination, zero immediate
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_REG:                   return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_X;
        endcase
    endfunction

    function automatic logic uses_rs1(input fmt_e f);
        return f inside {FMT_R, FMT_I, FMT_S, FMT_B};
    endfunction

    function automatic logic uses_rs2(input fmt_e f);
        return f inside {FMT_R, FMT_S, FMT_B};
    endfunction

    function automatic logic has_rd(input fmt_e f);
        return f inside {FMT_R, FMT_I, FMT_U, FMT_J};
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// rtl/id_operand_stage_if.sv - upstream instruction and downstream ID/EX handshake bundle
interface id_operand_stage_if;
    import rv32i_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm, out_rd
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm, out_rd
    );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction and sign extension
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt_of(instr[6:0]))
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - RV32I decode/operand-fetch stage with WB bypass and load-use interlock
module id_operand_stage #(
    parameter int XLEN             = 32,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    id_operand_stage_if.slave bus,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rs1_rdata,
    input  logic [XLEN-1:0]   rs2_rdata,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush
);
    import rv32i_pkg::*;

    fmt_e            in_fmt;
    fmt_e            held_fmt;
    logic            in_use1, in_use2, held_use1, held_use2;
    logic            load_use_stall, in_ready, accept, xfer;
    logic [XLEN-1:0] in_imm;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [1:0]      bub_cnt_q, bub_cnt_d;

    // The register file writes on the same edge we capture, so a matching writeback must be forwarded
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rdata,
        input logic            used,
        input logic            wen,
        input logic [4:0]      wrd,
        input logic [XLEN-1:0] wdata
    );
        if (!used || addr == 5'd0) return '0;
        if (wen && wrd == addr)    return wdata;
        return rdata;
    endfunction

    imm_gen u_imm_gen (
        .instr (bus.in_instr),
        .imm   (in_imm)
    );

    assign rs1_addr  = bus.in_instr[19:15];
    assign rs2_addr  = bus.in_instr[24:20];
    assign in_fmt    = fmt_of(bus.in_instr[6:0]);
    assign held_fmt  = fmt_of(instr_q[6:0]);
    assign in_use1   = uses_rs1(in_fmt);
    assign in_use2   = uses_rs2(in_fmt);
    assign held_use1 = uses_rs1(held_fmt);
    assign held_use2 = uses_rs2(held_fmt);

    assign load_use_stall = (bub_cnt_q != 2'd0) && bus.in_valid &&
                            ((in_use1 && rs1_addr == ld_rd_q) || (in_use2 && rs2_addr == ld_rd_q));
    assign in_ready = !flush && (!valid_q || bus.out_ready) && !load_use_stall;
    assign accept   = bus.in_valid && in_ready;
    assign xfer     = valid_q && bus.out_ready;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        if (accept) begin
            pc_d      = bus.in_pc;
            instr_d   = bus.in_instr;
            imm_d     = in_imm;
            rd_d      = has_rd(in_fmt) ? bus.in_instr[11:7] : 5'd0;
            rs1_val_d = resolve(rs1_addr, rs1_rdata, in_use1, wb_en, wb_rd, wb_data);
            rs2_val_d = resolve(rs2_addr, rs2_rdata, in_use2, wb_en, wb_rd, wb_data);
        end else if (valid_q && !bus.out_ready && wb_en && wb_rd != 5'd0) begin
            // A stalled instruction must still see writebacks that land while it waits
            if (held_use1 && wb_rd == instr_q[19:15]) rs1_val_d = wb_data;
            if (held_use2 && wb_rd == instr_q[24:20]) rs2_val_d = wb_data;
        end
        if (flush)       valid_d = 1'b0;
        else if (accept) valid_d = 1'b1;
        else if (xfer)   valid_d = 1'b0;
    end

    always_comb begin
        bub_cnt_d = bub_cnt_q;
        ld_rd_d   = ld_rd_q;
        if (flush) begin
            bub_cnt_d = 2'd0;
        end else if (xfer && instr_q[6:0] == OP_LOAD && rd_q != 5'd0) begin
            bub_cnt_d = 2'(LOAD_USE_BUBBLES);
            ld_rd_d   = rd_q;
        end else if (bub_cnt_q != 2'd0) begin
            bub_cnt_d = bub_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            ld_rd_q   <= '0;
            bub_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            ld_rd_q   <= ld_rd_d;
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_instr   = instr_q;
    assign bus.out_rs1_val = rs1_val_q;
    assign bus.out_rs2_val = rs2_val_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_rd      = rd_q;

endmodule
